// File: rtl/serial_tx_pkg.sv
// Shared types and width helpers for the serial symbol transmitter.
//   tx_state_e : transmitter FSM states
//   cnt_w      : counter width for a 0..n-1 count (minimum 1 bit)
//   div_cnt_w  : width of the per-bit clock divider counter
//   bit_cnt_w  : width of the bit-in-symbol counter
package serial_tx_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } tx_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned div_cnt_w(input int unsigned bit_div);
    return cnt_w(bit_div);
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned sym_w);
    return cnt_w(sym_w);
  endfunction

endpackage

// File: rtl/serial_sym_tx_if.sv
// Symbol input handshake bundle for serial_sym_tx.
//   s_data  : symbol value
//   s_valid : s_data valid (source -> transmitter)
//   s_ready : transmitter holding register can accept (transmitter -> source)
interface serial_sym_tx_if #(
  parameter int unsigned SYM_W = 5
);
  logic [SYM_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/serial_shift_core.sv
// Shift engine: serialises one symbol at BIT_DIV clocks per bit.
//   clk, rst      : clock, asynchronous active-high reset
//   load_i        : start a new symbol from sym_i on this edge (only when idle or on the
//                   final cycle of the current symbol)
//   sym_i         : symbol to load
//   dout_o        : serial bit, IDLE_LVL when not shifting
//   dout_vld_o    : shifting a symbol
//   bit_strobe_o  : first cycle of each bit
//   sym_done_o    : final cycle of the symbol's last bit
// All outputs are registers computed from next-state values so they line up with the
// cycle they describe.
module serial_shift_core
  import serial_tx_pkg::*;
#(
  parameter int unsigned SYM_W     = 5,
  parameter int unsigned BIT_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             dout_o,
  output logic             dout_vld_o,
  output logic             bit_strobe_o,
  output logic             sym_done_o
);

  localparam int unsigned DivW = div_cnt_w(BIT_DIV);
  localparam int unsigned BitW = bit_cnt_w(SYM_W);
  localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(SYM_W - 1);

  logic [SYM_W-1:0] sreg_q, sreg_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             dout_q, dout_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;

  always_comb begin
    sreg_d = sreg_q;
    div_d  = div_q;
    bit_d  = bit_q;
    vld_d  = vld_q;
    if (load_i) begin
      sreg_d = sym_i;
      div_d  = '0;
      bit_d  = '0;
      vld_d  = 1'b1;
    end else if (vld_q) begin
      if (div_q == DivLast) begin
        div_d = '0;
        if (bit_q == BitLast) begin
          vld_d = 1'b0;
          bit_d = '0;
        end else begin
          bit_d  = bit_q + 1'b1;
          // Outgoing bit always sits at the end nearest the output tap.
          sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    dout_d   = vld_d ? (MSB_FIRST ? sreg_d[SYM_W-1] : sreg_d[0]) : IDLE_LVL;
    strobe_d = vld_d & (div_d == '0);
    done_d   = vld_d & (div_d == DivLast) & (bit_d == BitLast);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      vld_q    <= 1'b0;
      dout_q   <= IDLE_LVL;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_vld_o   = vld_q;
  assign bit_strobe_o = strobe_q;
  assign sym_done_o   = done_q;

endmodule

// File: rtl/serial_sym_tx.sv
// Symbol-to-serial transmitter for the modulator baseband path.
//   clk, rst     : clock, asynchronous active-high reset
//   s_if         : symbol handshake (slave side: s_data, s_valid in; s_ready out)
//   mode_i       : 0 external symbols, 1 internal 0..PAT_MAX counting pattern
//   enable_i     : shifter may start new symbols
//   dout_o       : serial data
//   dout_vld_o   : dout carries a symbol bit
//   bit_strobe_o : first cycle of each bit
//   sym_done_o   : last cycle of each symbol
//   busy_o       : shifter active or holding register full
// A one-entry holding register sits in front of the shift engine so the next symbol is
// ready on the final cycle of the current one and symbols go out back to back.
module serial_sym_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned SYM_W     = 5,
  parameter int unsigned BIT_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned PAT_MAX   = 9,
  parameter bit          IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  serial_sym_tx_if.slave   s_if,
  input  logic             mode_i,
  input  logic             enable_i,
  output logic             dout_o,
  output logic             dout_vld_o,
  output logic             bit_strobe_o,
  output logic             sym_done_o,
  output logic             busy_o
);

  if ((SYM_W < 1) || (BIT_DIV < 1) || ((PAT_MAX >> SYM_W) != 0)) begin : g_param_chk
    $error("serial_sym_tx: need SYM_W>=1, BIT_DIV>=1 and PAT_MAX < 2**SYM_W");
  end

  localparam logic [SYM_W-1:0] PatMax = SYM_W'(PAT_MAX);

  tx_state_e        state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [SYM_W-1:0] hold_q, hold_d;
  logic [SYM_W-1:0] pat_q, pat_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;

  logic s_ready;
  logic ext_take;
  logic pat_take;
  logic shift_load;
  logic mode_latch;
  logic sym_done;

  // Ready depends only on registered state, never on the shifter draining this cycle.
  assign s_ready     = ~rst & ~hold_full_q & ~mode_q;
  assign s_if.s_ready = s_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i & hold_full_q) state_d = StShift;
      end
      StShift: begin
        if (sym_done & ~(enable_i & hold_full_q)) state_d = StIdle;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    shift_load = 1'b0;
    mode_latch = 1'b0;
    unique case (state_q)
      StIdle: begin
        shift_load = enable_i & hold_full_q;
        mode_latch = ~hold_full_q;
      end
      StShift: begin
        // Reload on the final cycle keeps consecutive symbols gapless.
        shift_load = sym_done & enable_i & hold_full_q;
      end
    endcase
  end

  // Holding register, pattern counter and mode latch.
  always_comb begin
    pat_take = mode_q & ~hold_full_q;
    ext_take = s_if.s_valid & s_ready;

    hold_full_d = (hold_full_q & ~shift_load) | pat_take | ext_take;
    hold_d      = hold_q;
    if (pat_take) begin
      hold_d = pat_q;
    end else if (ext_take) begin
      hold_d = s_if.s_data;
    end

    pat_d = pat_q;
    if (pat_take) begin
      pat_d = (pat_q == PatMax) ? '0 : pat_q + 1'b1;
    end

    mode_d = mode_latch ? mode_i : mode_q;
    busy_d = (state_d == StShift) | hold_full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      pat_q       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
    end
  end

  serial_shift_core #(
    .SYM_W    (SYM_W),
    .BIT_DIV  (BIT_DIV),
    .MSB_FIRST(MSB_FIRST),
    .IDLE_LVL (IDLE_LVL)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (shift_load),
    .sym_i       (hold_q),
    .dout_o      (dout_o),
    .dout_vld_o  (dout_vld_o),
    .bit_strobe_o(bit_strobe_o),
    .sym_done_o  (sym_done)
  );

  assign sym_done_o = sym_done;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_serial_sym_tx.sv
// Bench for serial_sym_tx: three instances (BIT_DIV=4 MSB-first, BIT_DIV=1 MSB-first,
// BIT_DIV=4 LSB-first), each shadowed by a symbol-level model that tracks one time index
// per symbol; a single compare process checks every output of every instance each cycle.
module tb_serial_sym_tx;

  localparam int unsigned SYM  = 5;
  localparam int unsigned PMAX = 9;
  localparam int unsigned NI   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]  md, en, sval;
  logic [SYM-1:0] sdat [NI];
  wire  [NI-1:0]  dout, vld, stb, done, busy, srdy;
  wire  [5:0]     exp_vec [NI];
  wire  [5:0]     act_vec [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned BD = (g == 1) ? 1 : 4;
    localparam bit          MF = (g != 2);

    serial_sym_tx_if #(.SYM_W(SYM)) sif ();
    assign sif.s_data  = sdat[g];
    assign sif.s_valid = sval[g];
    assign srdy[g]     = sif.s_ready;

    serial_sym_tx #(
      .SYM_W    (SYM),
      .BIT_DIV  (BD),
      .MSB_FIRST(MF),
      .PAT_MAX  (PMAX),
      .IDLE_LVL (1'b0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .s_if        (sif),
      .mode_i      (md[g]),
      .enable_i    (en[g]),
      .dout_o      (dout[g]),
      .dout_vld_o  (vld[g]),
      .bit_strobe_o(stb[g]),
      .sym_done_o  (done[g]),
      .busy_o      (busy[g])
    );

    // Model: hold slot, current symbol and elapsed cycles t within it (0..SYM*BD-1).
    logic           m_mode, m_full, m_busy;
    logic [SYM-1:0] m_hold, m_cur, m_pat;
    int unsigned    m_t;
    logic [2:0]     m_idx;

    always @(posedge clk or posedge rst) begin : model
      logic acc, ends, start;
      if (rst) begin
        m_mode <= 1'b0;
        m_full <= 1'b0;
        m_busy <= 1'b0;
        m_hold <= '0;
        m_cur  <= '0;
        m_pat  <= '0;
        m_t    <= 0;
      end else begin
        acc   = m_mode ? !m_full : (sval[g] && !m_full);
        ends  = m_busy && (m_t == SYM * BD - 1);
        start = en[g] && m_full && (!m_busy || ends);
        if (!m_busy && !m_full) m_mode <= md[g];
        if (m_mode && !m_full) m_pat <= (m_pat == PMAX) ? 5'd0 : m_pat + 5'd1;
        if (start) begin
          m_cur  <= m_hold;
          m_t    <= 0;
          m_busy <= 1'b1;
        end else if (ends) begin
          m_busy <= 1'b0;
        end else if (m_busy) begin
          m_t <= m_t + 1;
        end
        if (acc) begin
          m_full <= 1'b1;
          m_hold <= m_mode ? m_pat : sdat[g];
        end else if (start) begin
          m_full <= 1'b0;
        end
      end
    end

    assign m_idx = 3'(MF ? (SYM - 1 - m_t / BD) : (m_t / BD));
    assign exp_vec[g] = {m_busy ? m_cur[m_idx] : 1'b0,
                         m_busy,
                         m_busy && (m_t % BD == 0),
                         m_busy && (m_t == SYM * BD - 1),
                         m_busy || m_full,
                         !rst && !m_full && !m_mode};
    assign act_vec[g] = {dout[g], vld[g], stb[g], done[g], busy[g], srdy[g]};
  end

  string fname [6] = '{"s_ready", "busy", "sym_done", "bit_strobe", "dout_vld", "dout"};
  int    cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      for (int b = 0; b < 6; b++) begin
        checks++;
        if (act_vec[i][b] !== exp_vec[i][b]) begin
          errors++;
          $display("FAIL model cyc %0d inst%0d %s: got %b want %b",
                   cyc, i, fname[b], act_vec[i][b], exp_vec[i][b]);
        end
      end
    end
  end

  // Bit collector for the pattern instance and activity stats for instance 0.
  bit col_en = 1'b0;
  bit st_en  = 1'b0;
  bit bitq [$];
  int vld_cnt = 0, done_cnt = 0, run = 0, max_run = 0;

  always @(negedge clk) begin
    if (col_en && vld[1] && stb[1]) bitq.push_back(dout[1]);
    if (st_en) begin
      if (vld[0]) begin
        vld_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done[0]) done_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic send(input int i, input logic [SYM-1:0] d);
    bit r;
    r       = 1'b0;
    sdat[i] = d;
    sval[i] = 1'b1;
    for (int n = 0; n < 60 && !r; n++) begin
      @(negedge clk);
      r = srdy[i];
      @(posedge clk);
      #2;
    end
    sval[i] = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst%0d: got no handshake want handshake", i);
    end
  endtask

  // Expects a 4-clock-per-bit symbol starting on the next edge; w lists dout in time order.
  task automatic expect_wave(input int i, input string nm, input logic [19:0] w);
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("%s_dout_c%0d", nm, c), {31'd0, dout[i]}, {31'd0, w[19-c]});
      chk($sformatf("%s_vld_c%0d", nm, c), {31'd0, vld[i]}, 32'd1);
    end
    chk($sformatf("%s_done_last", nm), {31'd0, done[i]}, 32'd1);
  endtask

  int exp_pat [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

  initial begin : stim
    logic [4:0] s;
    md   = '0;
    en   = '0;
    sval = '0;
    for (int i = 0; i < NI; i++) sdat[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset while a symbol is being shifted.
    en[0] = 1'b1;
    send(0, 5'h1F);
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_vld", {31'd0, vld[0]}, 32'd1);
    chk("pre_rst_dout", {31'd0, dout[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_dout", {31'd0, dout[0]}, 32'd0);
    chk("rst_vld", {31'd0, vld[0]}, 32'd0);
    chk("rst_srdy", {31'd0, srdy[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("post_rst_srdy", {31'd0, srdy[0]}, 32'd1);

    // Single MSB-first symbol.
    @(posedge clk);
    #2;
    send(0, 5'b10110);
    expect_wave(0, "single", 20'b1111_0000_1111_1111_0000);
    @(posedge clk);
    #2;
    chk("single_idle_vld", {31'd0, vld[0]}, 32'd0);
    chk("single_idle_busy", {31'd0, busy[0]}, 32'd0);

    // Back-to-back symbols.
    st_en = 1'b1;
    send(0, 5'h15);
    send(0, 5'h0A);
    repeat (50) @(posedge clk);
    #2 st_en = 1'b0;
    chk("b2b_vld_cycles", vld_cnt, 40);
    chk("b2b_sym_done", done_cnt, 2);
    chk("b2b_contiguous", max_run, 40);

    // LSB-first instance.
    en[2] = 1'b1;
    send(2, 5'b00011);
    expect_wave(2, "lsb", 20'b1111_1111_0000_0000_0000);

    // Enable dropped mid-symbol with the next symbol held.
    @(posedge clk);
    #2;
    send(0, 5'h13);
    send(0, 5'b01101);
    en[0] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!vld[0]) break;
    end
    chk("endrop_vld", {31'd0, vld[0]}, 32'd0);
    chk("endrop_busy", {31'd0, busy[0]}, 32'd1);
    chk("endrop_srdy", {31'd0, srdy[0]}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("endrop_still_idle", {31'd0, vld[0]}, 32'd0);
    en[0] = 1'b1;
    expect_wave(0, "resume", 20'b0000_1111_1111_0000_1111);

    // Internal pattern at one clock per bit.
    @(posedge clk);
    #2;
    en[1]  = 1'b1;
    md[1]  = 1'b1;
    col_en = 1'b1;
    repeat (80) @(posedge clk);
    #2 col_en = 1'b0;
    chk("pat_srdy", {31'd0, srdy[1]}, 32'd0);
    chk("pat_enough_bits", {31'd0, bitq.size() >= 60}, 32'd1);
    if (bitq.size() >= 60) begin
      for (int k = 0; k < 12; k++) begin
        s = '0;
        for (int b = 0; b < 5; b++) s = {s[3:0], bitq[k*5+b]};
        chk($sformatf("pat_sym%0d", k), {27'd0, s}, exp_pat[k]);
      end
    end

    // Randomised traffic on all instances, with one reset pulse.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      sval[0] = ($urandom_range(0, 9) < 6);
      sdat[0] = 5'($urandom);
      en[0]   = ($urandom_range(0, 9) != 0);
      sval[2] = ($urandom_range(0, 9) < 5);
      sdat[2] = 5'($urandom);
      en[2]   = ($urandom_range(0, 7) != 0);
      en[1]   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) md[2] = ~md[2];
      if ($urandom_range(0, 29) == 0) md[1] = ~md[1];
      if (c == 900) rst = 1'b1;
      if (c == 902) rst = 1'b0;
    end
    sval = '0;
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
